fifo_read_packer: RTL and testbench

- Read-clock-domain consumer that sits directly downstream of the asynchronous FIFO read port.
- Pops bytes whenever the FIFO is non-empty and packs PACK bytes into one wide word, little-endian.
- Presents each word on a valid/ready master interface.
- Emits a partial, zero-padded word after an idle timeout or on an explicit flush, so trailing bytes are never stranded.

---
 rtl/fifo_pack_pkg.sv | 18 +
 rtl/idle_timer.sv | 34 +++
 rtl/fifo_read_packer.sv | 124 ++++++++++++
 tb/tb_fifo_read_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared defaults and derived widths for the FIFO read-side byte packer.
// Also carries the width helper used to size counters from their maximum value.
package fifo_pack_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PACK       = 4;
   localparam int DEF_TIMEOUT    = 16;

   // Bits needed to hold every value in 0..max_val.
   function automatic int width_for(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int WORD_WIDTH = DEF_DATA_WIDTH * DEF_PACK;
   localparam int CNT_WIDTH  = width_for(DEF_PACK);
   localparam int TMR_WIDTH  = width_for(DEF_TIMEOUT);

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter: counts enabled cycles up to TIMEOUT and flags expiry.
// expired is raised in the cycle the count reaches TIMEOUT, and stays up while saturated.
module idle_timer
   import fifo_pack_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic read_clk,
   input  logic write_rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int TMR_W = width_for(TIMEOUT);
   localparam logic [TMR_W-1:0] TC    = TMR_W'(TIMEOUT);
   localparam logic [TMR_W-1:0] TC_M1 = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge read_clk or posedge write_rst) begin
      if (write_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != TC)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Independent of clr so the packer can use expiry to decide whether to clear.
   assign expired = (cnt == TC) || (en && (cnt == TC_M1));

endmodule

// File: rtl/fifo_read_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into wide words,
// emitting zero-padded partial words on idle timeout or flush.
module fifo_read_packer
   import fifo_pack_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PACK       = DEF_PACK,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                          read_clk,
   input  logic                          write_rst,
   input  logic                          fifo_empty,
   input  logic [DATA_WIDTH-1:0]         fifo_rdata,
   output logic                          fifo_rd_en,
   input  logic                          flush,
   output logic [DATA_WIDTH*PACK-1:0]    m_data,
   output logic [width_for(PACK)-1:0]    m_bytes,
   output logic                          m_valid,
   input  logic                          m_ready
);

   localparam int W_WORD = DATA_WIDTH * PACK;
   localparam int W_CNT  = width_for(PACK);
   localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(PACK);
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(PACK - 1);

   logic [DATA_WIDTH-1:0] acc [PACK];
   logic [W_CNT-1:0]      count;
   logic                  pending;
   logic                  flush_req;

   logic              acc_full;
   logic              out_free;
   logic              load_full;
   logic              pop_ok;
   logic              partial_go;
   logic              timer_en;
   logic              timer_clr;
   logic              timed_out;
   logic [W_WORD-1:0] acc_word;

   assign acc_full  = (count == CNT_FULL);
   assign out_free  = !m_valid || m_ready;
   assign load_full = acc_full && out_free;

   // A full word draining this cycle frees slot 0, so a pop may overlap the load.
   // pop_ok excludes partial-emit suppression so the timer never depends on its own expiry.
   assign pop_ok = !fifo_empty &&
                   (load_full || (!acc_full && !(pending && (count == CNT_LAST))));

   assign partial_go = (timed_out || flush_req) && !pending && (count != '0) &&
                       out_free && !load_full;

   assign fifo_rd_en = pop_ok && !partial_go && !write_rst;

   assign timer_en  = (count != '0) && !pending && !pop_ok;
   assign timer_clr = fifo_rd_en || (count == '0) || partial_go;

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .read_clk  (read_clk),
      .write_rst (write_rst),
      .en        (timer_en),
      .clr       (timer_clr),
      .expired   (timed_out)
   );

   // Slots at or above count read as zero, giving the padded partial word for free.
   always_comb begin
      acc_word = '0;
      for (int i = 0; i < PACK; i++) begin
         if (W_CNT'(i) < count) begin
            acc_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
         end
      end
   end

   always_ff @(posedge read_clk or posedge write_rst) begin
      if (write_rst) begin
         count     <= '0;
         pending   <= 1'b0;
         flush_req <= 1'b0;
         for (int i = 0; i < PACK; i++) begin
            acc[i] <= '0;
         end
      end else begin
         pending <= fifo_rd_en;

         if (load_full || partial_go) begin
            count <= '0;
         end else if (pending) begin
            count <= count + 1'b1;
         end

         for (int i = 0; i < PACK; i++) begin
            if (pending && (count == W_CNT'(i))) begin
               acc[i] <= fifo_rdata;
            end
         end

         if (flush) begin
            flush_req <= 1'b1;
         end else if (partial_go || (flush_req && (count == '0) && !pending)) begin
            flush_req <= 1'b0;
         end
      end
   end

   always_ff @(posedge read_clk or posedge write_rst) begin
      if (write_rst) begin
         m_data  <= '0;
         m_bytes <= '0;
         m_valid <= 1'b0;
      end else if (load_full || partial_go) begin
         m_data  <= acc_word;
         m_bytes <= count;
         m_valid <= 1'b1;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: table vectors, directed corner sequences and a randomized
// run scored against a byte-queue reference model.
module tb_fifo_read_packer;
   import fifo_pack_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int PK = DEF_PACK;
   localparam int TO = DEF_TIMEOUT;

   logic                  read_clk   = 1'b0;
   logic                  write_rst  = 1'b0;
   logic                  fifo_empty = 1'b1;
   logic [DW-1:0]         fifo_rdata = '0;
   logic                  fifo_rd_en;
   logic                  flush      = 1'b0;
   logic [WORD_WIDTH-1:0] m_data;
   logic [CNT_WIDTH-1:0]  m_bytes;
   logic                  m_valid;
   logic                  m_ready    = 1'b0;

   fifo_read_packer #(
      .DATA_WIDTH (DW),
      .PACK       (PK),
      .TIMEOUT    (TO)
   ) dut (
      .read_clk   (read_clk),
      .write_rst  (write_rst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .m_data     (m_data),
      .m_bytes    (m_bytes),
      .m_valid    (m_valid),
      .m_ready    (m_ready)
   );

   always #5 read_clk = ~read_clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: no word observed within the cycle budget", name);
   endtask

   always @(posedge read_clk) cyc <= cyc + 1;

   // FIFO model: one-cycle read latency, optional random empty gaps.
   logic [DW-1:0] fq[$];
   bit            gap_mode      = 1'b0;
   int            underflow     = 0;
   int            last_pop_edge = 0;

   always @(posedge read_clk) begin
      if (fifo_rd_en) begin
         last_pop_edge = cyc + 1;
         if (fq.size() == 0) underflow++;
         else fifo_rdata <= fq.pop_front();
      end
   end

   always @(negedge read_clk)
      fifo_empty <= (fq.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));

   // Monitor: records handshakes and checks stability under backpressure.
   typedef struct {
      logic [WORD_WIDTH-1:0] data;
      int                    bytes;
      int                    cyc;
   } obs_t;

   obs_t                  obs_q[$];
   bit                    prev_stall = 1'b0;
   logic [WORD_WIDTH-1:0] prev_data;
   logic [CNT_WIDTH-1:0]  prev_bytes;

   always @(negedge read_clk) begin
      if (write_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_data", m_data, prev_data);
            check("hold_bytes", m_bytes, prev_bytes);
         end
         if (m_valid && m_ready) obs_q.push_back('{m_data, int'(m_bytes), cyc});
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_bytes = m_bytes;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge read_clk);
         #2;
      end
   endtask

   task automatic expect_word(input string name, input logic [WORD_WIDTH-1:0] d,
                              input int nb, output int at_cyc);
      obs_t o;
      int   waited;
      waited = 0;
      at_cyc = -1;
      while (obs_q.size() == 0 && waited < 200) begin
         tick();
         waited++;
      end
      if (obs_q.size() == 0) begin
         fail_now(name);
      end else begin
         o = obs_q.pop_front();
         check({name, "_data"}, o.data, d);
         check({name, "_bytes"}, o.bytes, nb);
         at_cyc = o.cyc;
      end
   endtask

   task automatic expect_quiet(input string name, input int n);
      tick(n);
      check({name, "_no_word"}, obs_q.size(), 0);
      check({name, "_valid_low"}, m_valid, 1'b0);
   endtask

   typedef struct {
      int            n;
      logic [7:0]    b0, b1, b2, b3;
      bit            use_flush;
      logic [31:0]   exp_data;
      int            exp_bytes;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs[NV];

   logic [7:0]  ref_q[$];

   initial begin
      int          at;
      int          at2;
      logic [7:0]  bl[4];
      logic [31:0] exp_a[4];
      obs_t        o;
      logic [31:0] w;
      int          nb;
      int          budget;

      vecs[0] = '{4, 8'h11, 8'h12, 8'h13, 8'h14, 1'b0, 32'h14131211, 4};
      vecs[1] = '{3, 8'h21, 8'h22, 8'h23, 8'h00, 1'b0, 32'h00232221, 3};
      vecs[2] = '{2, 8'hAA, 8'hBB, 8'h00, 8'h00, 1'b1, 32'h0000BBAA, 2};
      vecs[3] = '{1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0000005A, 1};
      vecs[4] = '{1, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 32'h00000077, 1};
      vecs[5] = '{4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 32'hEFBEADDE, 4};
      vecs[6] = '{3, 8'h01, 8'h80, 8'hFF, 8'h00, 1'b1, 32'h00FF8001, 3};

      #1 write_rst = 1'b1;
      #1;
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_data", m_data, 0);
      check("rst_bytes", m_bytes, 0);
      tick(3);
      write_rst = 1'b0;
      m_ready   = 1'b1;
      tick(2);

      // Table vectors: full words, timeout partials and flush partials.
      for (int i = 0; i < NV; i++) begin
         bl[0] = vecs[i].b0; bl[1] = vecs[i].b1; bl[2] = vecs[i].b2; bl[3] = vecs[i].b3;
         for (int k = 0; k < vecs[i].n; k++) fq.push_back(bl[k]);
         if (vecs[i].use_flush) begin
            tick(6);
            flush = 1'b1;
            tick();
            flush = 1'b0;
         end
         expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_bytes, at);
         if (!vecs[i].use_flush && vecs[i].n < PK && at >= 0)
            check($sformatf("vec%0d_latency", i), at - last_pop_edge, TO + 1);
         expect_quiet($sformatf("vec%0d_after", i), TO + 4);
      end

      // Flush with an empty accumulator produces nothing.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      expect_quiet("flush_empty", TO + 5);

      // Sixteen bytes streamed with the sink always ready.
      exp_a = '{32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D};
      for (int b = 17; b <= 32; b++) fq.push_back(8'(b));
      for (int k = 0; k < 4; k++) expect_word($sformatf("stream%0d", k), exp_a[k], 4, at);
      expect_quiet("stream_end", TO + 5);
      check("stream_fifo_empty", fifo_empty, 1'b1);

      // Backpressure: first word held, accumulator full, ninth byte left in the FIFO.
      m_ready = 1'b0;
      for (int b = 1; b <= 9; b++) fq.push_back(8'(b));
      tick(20);
      check("bp_valid", m_valid, 1'b1);
      check("bp_data", m_data, 32'h04030201);
      check("bp_bytes", m_bytes, 4);
      check("bp_rd_en", fifo_rd_en, 1'b0);
      check("bp_fifo_left", fq.size(), 1);
      m_ready = 1'b1;
      expect_word("bp_w1", 32'h04030201, 4, at);
      expect_word("bp_w2", 32'h08070605, 4, at2);
      check("bp_back_to_back", at2 - at, 1);
      expect_word("bp_tail", 32'h00000009, 1, at);
      expect_quiet("bp_end", TO + 4);

      // Reset with two bytes held and a third pop in flight.
      for (int b = 'h51; b <= 'h53; b++) fq.push_back(8'(b));
      tick(3);
      write_rst = 1'b1;
      #1;
      check("mrst_rd_en", fifo_rd_en, 1'b0);
      check("mrst_valid", m_valid, 1'b0);
      check("mrst_data", m_data, 0);
      check("mrst_bytes", m_bytes, 0);
      tick(2);
      write_rst = 1'b0;
      check("mrst_no_word", obs_q.size(), 0);
      for (int b = 'h11; b <= 'h14; b++) fq.push_back(8'(b));
      expect_word("mrst_clean", 32'h14131211, 4, at);
      expect_quiet("mrst_end", TO + 6);

      // Random run: FIFO gaps and random m_ready against a byte-order scoreboard.
      gap_mode = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         logic [7:0] rb;
         rb = 8'($urandom_range(0, 255));
         fq.push_back(rb);
         ref_q.push_back(rb);
      end
      budget = 0;
      while (ref_q.size() > 0 && budget < 20000) begin
         m_ready = ($urandom_range(0, 2) != 0);
         tick();
         budget++;
         while (obs_q.size() > 0 && ref_q.size() > 0) begin
            o  = obs_q.pop_front();
            nb = (ref_q.size() >= PK) ? PK : ref_q.size();
            w  = '0;
            for (int k = 0; k < nb; k++) w = w | (32'(ref_q.pop_front()) << (8 * k));
            check("rand_bytes", o.bytes, nb);
            check("rand_data", o.data, w);
         end
      end
      gap_mode = 1'b0;
      m_ready  = 1'b1;
      check("rand_all_received", ref_q.size(), 0);
      expect_quiet("rand_end", TO + 6);
      check("fifo_underflow", underflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
